// File: rtl/conv_layer_sched.sv
// Descriptor-table sequencer for the conv/maxpool datapath: start->cnt_en 2 cycles, result_done->clear 1 cycle.
// Pulse-driven, no backpressure. Optional watchdog (err) with `define CONV_SCHED_WDOG_EN.
module conv_layer_sched #(
    parameter int NUM_LAYERS = 3,
    parameter int DIM_W      = 9,
    parameter int WDOG_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_idx,
    input  logic [DIM_W-1:0] i_cfg_ht_sm,
    input  logic [DIM_W-1:0] i_cfg_wt_sm,
    input  logic [DIM_W-1:0] i_cfg_ht_lg,
    input  logic [DIM_W-1:0] i_cfg_wt_lg,
    input  logic [1:0]       i_cfg_sel,
    input  logic             i_cfg_mode,
    input  logic             i_scan_done,
    input  logic             i_result_done,
    output logic [DIM_W-1:0] o_ht_sm,
    output logic [DIM_W-1:0] o_wt_sm,
    output logic [DIM_W-1:0] o_ht_lg,
    output logic [DIM_W-1:0] o_wt_lg,
    output logic [1:0]       o_sel,
    output logic             o_cnt_en_l1,
    output logic             o_cnt_en_l2,
    output logic             o_conv_en,
    output logic             o_wr_en,
    output logic             o_clear,
    output logic [1:0]       o_layer_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CLEAR, S_NEXT} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_LAYERS - 1);

    // Table is always 4 deep; entries at or above NUM_LAYERS are never written and stay zero.
    logic [DIM_W-1:0] r_tab_ht_sm [4];
    logic [DIM_W-1:0] r_tab_wt_sm [4];
    logic [DIM_W-1:0] r_tab_ht_lg [4];
    logic [DIM_W-1:0] r_tab_wt_lg [4];
    logic [1:0]       r_tab_sel   [4];
    logic             r_tab_mode  [4];

    state_t           r_state, w_state;
    logic [DIM_W-1:0] r_ht_sm, r_wt_sm, r_ht_lg, r_wt_lg;
    logic [DIM_W-1:0] w_ht_sm, w_wt_sm, w_ht_lg, w_wt_lg;
    logic [1:0]       r_sel, w_sel, r_layer_idx, w_layer_idx;
    logic             r_mode, w_mode;
    logic             r_cnt_en_l1, w_cnt_en_l1, r_cnt_en_l2, w_cnt_en_l2;
    logic             r_conv_en, w_conv_en, r_wr_en, w_wr_en, r_clear, w_clear;
    logic             r_busy, w_busy, r_done, w_done;
    logic             r_pend, w_pend, r_aborted, w_aborted;
    logic             w_kill, w_abort, w_wdog_fire, w_cfg_ok;

    logic [DIM_W-1:0] w_ent_ht_sm, w_ent_wt_sm, w_ent_ht_lg, w_ent_wt_lg;
    logic [1:0]       w_ent_sel;
    logic             w_ent_mode;

    assign w_cfg_ok = i_cfg_we && !r_busy && ({1'b0, i_cfg_idx} < 3'(NUM_LAYERS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_tab_ht_sm[i] <= '0;
                r_tab_wt_sm[i] <= '0;
                r_tab_ht_lg[i] <= '0;
                r_tab_wt_lg[i] <= '0;
                r_tab_sel[i]   <= '0;
                r_tab_mode[i]  <= 1'b0;
            end
        end else if (w_cfg_ok) begin
            r_tab_ht_sm[i_cfg_idx] <= i_cfg_ht_sm;
            r_tab_wt_sm[i_cfg_idx] <= i_cfg_wt_sm;
            r_tab_ht_lg[i_cfg_idx] <= i_cfg_ht_lg;
            r_tab_wt_lg[i_cfg_idx] <= i_cfg_wt_lg;
            r_tab_sel[i_cfg_idx]   <= i_cfg_sel;
            r_tab_mode[i_cfg_idx]  <= i_cfg_mode;
        end
    end

    assign w_ent_ht_sm = r_tab_ht_sm[r_layer_idx];
    assign w_ent_wt_sm = r_tab_wt_sm[r_layer_idx];
    assign w_ent_ht_lg = r_tab_ht_lg[r_layer_idx];
    assign w_ent_wt_lg = r_tab_wt_lg[r_layer_idx];
    assign w_ent_sel   = r_tab_sel[r_layer_idx];
    assign w_ent_mode  = r_tab_mode[r_layer_idx];

    assign w_abort = i_abort || w_wdog_fire;

    always_comb begin
        w_state     = r_state;
        w_ht_sm     = r_ht_sm;
        w_wt_sm     = r_wt_sm;
        w_ht_lg     = r_ht_lg;
        w_wt_lg     = r_wt_lg;
        w_sel       = r_sel;
        w_mode      = r_mode;
        w_cnt_en_l1 = r_cnt_en_l1;
        w_cnt_en_l2 = r_cnt_en_l2;
        w_conv_en   = r_conv_en;
        w_wr_en     = r_wr_en;
        w_clear     = 1'b0;
        w_layer_idx = r_layer_idx;
        w_busy      = r_busy;
        w_done      = r_done;
        w_pend      = r_pend;
        w_aborted   = r_aborted;
        w_kill      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state     = S_LOAD;
                    w_layer_idx = '0;
                    w_busy      = 1'b1;
                    w_done      = 1'b0;
                    w_pend      = 1'b0;
                    w_aborted   = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_abort) begin
                    w_kill = 1'b1;
                end else if (w_ent_ht_sm == '0) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_sel   = '0;
                end else begin
                    w_state     = S_RUN;
                    w_ht_sm     = w_ent_ht_sm;
                    w_wt_sm     = w_ent_wt_sm;
                    w_ht_lg     = w_ent_ht_lg;
                    w_wt_lg     = w_ent_wt_lg;
                    w_sel       = w_ent_sel;
                    w_mode      = w_ent_mode;
                    w_wr_en     = 1'b1;
                    w_cnt_en_l1 = !w_ent_mode;
                    w_cnt_en_l2 = w_ent_mode;
                    w_conv_en   = 1'b1;
                    w_pend      = 1'b0;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_kill = 1'b1;
                end else begin
                    // An early result_done must not be lost while the scan finishes.
                    if (i_result_done) begin
                        w_pend = 1'b1;
                    end
                    if (i_scan_done) begin
                        w_state     = S_DRAIN;
                        w_cnt_en_l1 = 1'b0;
                        w_cnt_en_l2 = 1'b0;
                        if (!r_mode) begin
                            w_conv_en = 1'b0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    w_kill = 1'b1;
                end else if (i_result_done || r_pend) begin
                    w_state   = S_CLEAR;
                    w_clear   = 1'b1;
                    w_wr_en   = 1'b0;
                    w_conv_en = 1'b0;
                end
            end
            S_CLEAR: begin
                if (i_abort || r_aborted) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b0;
                    w_sel   = '0;
                end else begin
                    w_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (i_abort) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b0;
                    w_sel   = '0;
                end else if (r_layer_idx == LAST_IDX) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_sel   = '0;
                end else begin
                    w_state     = S_LOAD;
                    w_layer_idx = r_layer_idx + 2'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_kill) begin
            w_state     = S_CLEAR;
            w_aborted   = 1'b1;
            w_clear     = 1'b1;
            w_cnt_en_l1 = 1'b0;
            w_cnt_en_l2 = 1'b0;
            w_conv_en   = 1'b0;
            w_wr_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ht_sm     <= '0;
            r_wt_sm     <= '0;
            r_ht_lg     <= '0;
            r_wt_lg     <= '0;
            r_sel       <= '0;
            r_mode      <= 1'b0;
            r_cnt_en_l1 <= 1'b0;
            r_cnt_en_l2 <= 1'b0;
            r_conv_en   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_clear     <= 1'b0;
            r_layer_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pend      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ht_sm     <= w_ht_sm;
            r_wt_sm     <= w_wt_sm;
            r_ht_lg     <= w_ht_lg;
            r_wt_lg     <= w_wt_lg;
            r_sel       <= w_sel;
            r_mode      <= w_mode;
            r_cnt_en_l1 <= w_cnt_en_l1;
            r_cnt_en_l2 <= w_cnt_en_l2;
            r_conv_en   <= w_conv_en;
            r_wr_en     <= w_wr_en;
            r_clear     <= w_clear;
            r_layer_idx <= w_layer_idx;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pend      <= w_pend;
            r_aborted   <= w_aborted;
        end
    end

`ifdef CONV_SCHED_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    assign w_wdog_fire = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (&r_wdog);

    // Restarts on every entry into RUN or DRAIN so each wait is bounded separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (((w_state == S_RUN) || (w_state == S_DRAIN)) && (w_state != r_state)) begin
            r_wdog <= '0;
        end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_err <= 1'b0;
        end else if (w_wdog_fire) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_wdog_fire = 1'b0;
    assign o_err       = 1'b0;
`endif

    assign o_ht_sm     = r_ht_sm;
    assign o_wt_sm     = r_wt_sm;
    assign o_ht_lg     = r_ht_lg;
    assign o_wt_lg     = r_wt_lg;
    assign o_sel       = r_sel;
    assign o_cnt_en_l1 = r_cnt_en_l1;
    assign o_cnt_en_l2 = r_cnt_en_l2;
    assign o_conv_en   = r_conv_en;
    assign o_wr_en     = r_wr_en;
    assign o_clear     = r_clear;
    assign o_layer_idx = r_layer_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: directed and randomized sequences against a descriptor-table model.
module tb_conv_layer_sched;
    localparam int NL = 3;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_abort, i_cfg_we;
    logic [1:0]    i_cfg_idx, i_cfg_sel;
    logic [DW-1:0] i_cfg_ht_sm, i_cfg_wt_sm, i_cfg_ht_lg, i_cfg_wt_lg;
    logic          i_cfg_mode, i_scan_done, i_result_done;
    logic [DW-1:0] o_ht_sm, o_wt_sm, o_ht_lg, o_wt_lg;
    logic [1:0]    o_sel, o_layer_idx;
    logic          o_cnt_en_l1, o_cnt_en_l2, o_conv_en, o_wr_en, o_clear;
    logic          o_busy, o_done, o_err;

    always #5 clk = ~clk;

    conv_layer_sched #(.NUM_LAYERS(NL), .DIM_W(DW), .WDOG_W(20)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_abort(i_abort), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
        .i_cfg_ht_sm(i_cfg_ht_sm), .i_cfg_wt_sm(i_cfg_wt_sm),
        .i_cfg_ht_lg(i_cfg_ht_lg), .i_cfg_wt_lg(i_cfg_wt_lg),
        .i_cfg_sel(i_cfg_sel), .i_cfg_mode(i_cfg_mode),
        .i_scan_done(i_scan_done), .i_result_done(i_result_done),
        .o_ht_sm(o_ht_sm), .o_wt_sm(o_wt_sm), .o_ht_lg(o_ht_lg), .o_wt_lg(o_wt_lg),
        .o_sel(o_sel), .o_cnt_en_l1(o_cnt_en_l1), .o_cnt_en_l2(o_cnt_en_l2),
        .o_conv_en(o_conv_en), .o_wr_en(o_wr_en), .o_clear(o_clear),
        .o_layer_idx(o_layer_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the descriptor table as the host believes it to be.
    logic [DW-1:0] m_ht_sm [4];
    logic [DW-1:0] m_wt_sm [4];
    logic [DW-1:0] m_ht_lg [4];
    logic [DW-1:0] m_wt_lg [4];
    logic [1:0]    m_sel   [4];
    logic          m_mode  [4];

    // Cumulative activity counters; read as before/after differences around a sequence.
    int n_clear_tot = 0;
    int l1_cnt [4];
    int l2_cnt [4];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (o_clear === 1'b1) n_clear_tot++;
            if (o_cnt_en_l1 === 1'b1) l1_cnt[o_layer_idx]++;
            if (o_cnt_en_l2 === 1'b1) l2_cnt[o_layer_idx]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_ht_sm[i] = '0; m_wt_sm[i] = '0; m_ht_lg[i] = '0; m_wt_lg[i] = '0;
            m_sel[i] = '0; m_mode[i] = 1'b0;
        end
    endtask

    // Host write while idle; the model keeps only indices inside the table.
    task automatic cfg_write(input int idx, input int hs, input int ws, input int hl,
                             input int wl, input int sel, input int mode);
        i_cfg_we = 1'b1; i_cfg_idx = 2'(idx);
        i_cfg_ht_sm = DW'(hs); i_cfg_wt_sm = DW'(ws);
        i_cfg_ht_lg = DW'(hl); i_cfg_wt_lg = DW'(wl);
        i_cfg_sel = 2'(sel); i_cfg_mode = 1'(mode);
        tick();
        i_cfg_we = 1'b0;
        if (idx < NL) begin
            m_ht_sm[idx] = DW'(hs); m_wt_sm[idx] = DW'(ws);
            m_ht_lg[idx] = DW'(hl); m_wt_lg[idx] = DW'(wl);
            m_sel[idx] = 2'(sel); m_mode[idx] = 1'(mode);
        end
    endtask

    // One full start..idle sequence, acting as address generator and result writer.
    task automatic run_seq(input bit same0, input int ab_layer, input int ab_cyc,
                           input bit poke, input bit start_with_abort);
        int  d, r, n_done, b_clear;
        int  b_l1 [4];
        int  b_l2 [4];
        bit  ran [4];
        bit  fin, aborted;
        n_done = 0; fin = 0; aborted = 0; b_clear = n_clear_tot;
        for (int i = 0; i < 4; i++) begin
            b_l1[i] = l1_cnt[i]; b_l2[i] = l2_cnt[i]; ran[i] = 0;
        end
        i_start = 1'b1; i_abort = 1'(start_with_abort);
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_done", 32'(o_done), 0);
        chk("start_idx", 32'(o_layer_idx), 0);
        for (int l = 0; l < NL && !fin; l++) begin
            if (m_ht_sm[l] == '0) begin
                tick();
                chk("marker_done", 32'(o_done), 1);
                chk("marker_busy", 32'(o_busy), 0);
                chk("marker_idx", 32'(o_layer_idx), 32'(l));
                chk("marker_sel", 32'(o_sel), 0);
                fin = 1;
            end else begin
                tick();
                ran[l] = 1;
                chk("run_sel", 32'(o_sel), 32'(m_sel[l]));
                chk("run_dims", {o_ht_sm, o_wt_sm, o_ht_lg[4:0]}, {m_ht_sm[l], m_wt_sm[l], m_ht_lg[l][4:0]});
                chk("run_wt_lg", 32'(o_wt_lg), 32'(m_wt_lg[l]));
                chk("run_cnt", {o_cnt_en_l1, o_cnt_en_l2}, {!m_mode[l], m_mode[l]});
                chk("run_conv_wr", {o_conv_en, o_wr_en}, 2'b11);
                chk("run_idx", 32'(o_layer_idx), 32'(l));
                d = $urandom_range(6, 25);
                for (int k = 1; k < d && !aborted; k++) begin
                    if (poke && l == 0 && k == 1) begin
                        i_start = 1'b1; i_cfg_we = 1'b1; i_cfg_idx = 2'd0; i_cfg_ht_sm = DW'(5);
                    end
                    if (l == ab_layer && k == ab_cyc) begin
                        i_abort = 1'b1;
                        tick();
                        i_abort = 1'b0;
                        chk("abort_clear", 32'(o_clear), 1);
                        chk("abort_enables", {o_cnt_en_l1, o_cnt_en_l2, o_conv_en, o_wr_en}, 0);
                        tick();
                        chk("abort_idle", {o_busy, o_done, o_clear}, 0);
                        aborted = 1;
                    end else begin
                        tick();
                        i_start = 1'b0; i_cfg_we = 1'b0;
                    end
                end
                if (aborted) begin
                    fin = 1;
                end else begin
                    i_scan_done = 1'b1;
                    i_result_done = 1'(same0 && l == 0);
                    tick();
                    i_scan_done = 1'b0; i_result_done = 1'b0;
                    chk("drain_cnt", {o_cnt_en_l1, o_cnt_en_l2}, 0);
                    chk("drain_conv", 32'(o_conv_en), 32'(m_mode[l]));
                    chk("drain_noclear", 32'(o_clear), 0);
                    if (same0 && l == 0) begin
                        tick();
                        chk("same_clear", 32'(o_clear), 1);
                    end else begin
                        r = $urandom_range(1, 5);
                        for (int j = 1; j < r; j++) tick();
                        chk("drain_wait", 32'(o_clear), 0);
                        i_result_done = 1'b1;
                        tick();
                        i_result_done = 1'b0;
                        chk("clear_pulse", 32'(o_clear), 1);
                    end
                    chk("clear_wr_conv", {o_wr_en, o_conv_en}, 0);
                    tick();
                    chk("clear_single", 32'(o_clear), 0);
                    n_done++;
                    tick();
                    if (l == NL - 1) begin
                        chk("end_done_busy", {o_done, o_busy}, 2'b10);
                        chk("end_sel_idx", {o_sel, o_layer_idx}, {2'b00, 2'(NL - 1)});
                    end else begin
                        chk("next_idx", {o_busy, o_layer_idx}, {1'b1, 2'(l + 1)});
                    end
                end
            end
        end
        chk("clear_count", 32'(n_clear_tot - b_clear), 32'(n_done + int'(aborted)));
        for (int l = 0; l < 4; l++) begin
            chk("l1_activity", 32'(l1_cnt[l] != b_l1[l]), 32'(ran[l] && !m_mode[l]));
            chk("l2_activity", 32'(l2_cnt[l] != b_l2[l]), 32'(ran[l] && m_mode[l]));
        end
        chk("err_low", 32'(o_err), 0);
    endtask

    initial begin
        rst = 1'b1; i_start = 0; i_abort = 0; i_cfg_we = 0; i_cfg_idx = 0; i_cfg_sel = 0;
        i_cfg_ht_sm = 0; i_cfg_wt_sm = 0; i_cfg_ht_lg = 0; i_cfg_wt_lg = 0; i_cfg_mode = 0;
        i_scan_done = 0; i_result_done = 0;
        model_clear();
        repeat (3) tick();
        chk("rst_dims", {o_ht_sm, o_wt_sm, o_ht_lg, o_wt_lg}, 0);
        chk("rst_ctrl", {o_sel, o_cnt_en_l1, o_cnt_en_l2, o_conv_en, o_wr_en, o_clear}, 0);
        chk("rst_status", {o_layer_idx, o_busy, o_done, o_err}, 0);
        rst = 1'b0;
        tick();

        // Reference three-layer program; the out-of-range write must have no effect.
        cfg_write(0, 3, 3, 30, 27, 1, 0);
        cfg_write(1, 3, 3, 440, 340, 2, 0);
        cfg_write(2, 28, 25, 438, 338, 3, 1);
        cfg_write(3, 0, 1, 1, 1, 1, 1);
        run_seq(0, -1, 0, 1, 0);

        repeat (3) tick();
        chk("done_hold", {o_done, o_busy}, 2'b10);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("idle_abort_ignored", {o_done, o_busy, o_clear}, 3'b100);

        run_seq(1, -1, 0, 0, 0);
        run_seq(0, 1, 5, 0, 0);
        run_seq(0, -1, 0, 0, 1);

        cfg_write(1, 0, 7, 7, 7, 2, 1);
        run_seq(0, -1, 0, 0, 0);

        for (int it = 0; it < 4; it++) begin
            for (int e = 0; e < NL; e++) begin
                cfg_write(e, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 511),
                          $urandom_range(1, 511), $urandom_range(1, 511), $urandom_range(1, 511),
                          $urandom_range(1, 3), $urandom_range(0, 1));
            end
            run_seq($urandom_range(0, 1), -1, 0, 0, 0);
        end

        // Reset mid-sequence wipes the table, so entry 0 becomes an end marker.
        cfg_write(0, 9, 9, 9, 9, 1, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("midrst_ctrl", {o_busy, o_done, o_cnt_en_l1, o_cnt_en_l2, o_conv_en, o_wr_en, o_sel}, 0);
        chk("midrst_dims", 32'(o_ht_sm), 0);
        run_seq(0, -1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
Descriptor-driven sequencer for the shared convolution/maxpool datapath. It holds a small table of layer descriptors, one per pass: filter pre-process, image pre-process, and correlation plus maxpool. It runs the passes in order by driving dimension registers, source select, counter enables, conv enable, write enable and clear pulses. It replaces hard-coded per-layer setup. It sits between the host start/done interface and the address generators, convolution engine and result RAMs.

Parameters:
NUM_LAYERS, 3, descriptor table depth (1..4)
DIM_W, 9, width of every dimension field
WDOG_W, 20, watchdog counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin sequence; single-cycle pulse
abort  in  1  stop current sequence; single-cycle pulse
cfg_we  in  1  descriptor write strobe
cfg_idx  in  2  descriptor index
cfg_ht_sm, cfg_wt_sm, cfg_ht_lg, cfg_wt_lg  in  DIM_W each  descriptor dimensions
cfg_sel  in  2  datapath source select for this layer (1..3)
cfg_mode  in  1  0 = sliding conv (l1 counter), 1 = conv+pool (l2 counter)
scan_done  in  1  pulse from the active address generator: last address issued
result_done  in  1  pulse: last result written (conv done for mode 0, pool done for mode 1)
ht_sm, wt_sm, ht_lg, wt_lg  out  DIM_W each  registered dimensions to the datapath
sel  out  2  source select
cnt_en_l1, cnt_en_l2, conv_en, wr_en, clear  out  1 each  datapath controls
layer_idx  out  2  current descriptor index
busy  out  1  sequence in progress
done  out  1  sequence complete; level
err  out  1  watchdog fault (0 when the optional feature is absent)

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- On reset: all outputs 0, state IDLE, all descriptor fields 0.
- Descriptor table:
  - cfg_we writes entry cfg_idx on the clock edge, only while busy=0; writes while busy are ignored.
  - cfg_idx >= NUM_LAYERS is ignored.
  - An entry with ht_sm==0 is an end marker.
- States are IDLE, LOAD, RUN, DRAIN, CLEAR, NEXT.
- IDLE:
  - start -> LOAD; layer_idx=0, busy=1, done=0, err=0.
  - abort is ignored in IDLE.
- LOAD (1 cycle):
  - If the entry is an end marker -> IDLE with done=1, busy=0, sel=0.
  - Otherwise register the dims and sel, set wr_en=1, set cnt_en_l1 (mode 0) or cnt_en_l2 (mode 1), then -> RUN.
- RUN:
  - conv_en=1 from the first RUN cycle.
  - On scan_done: drop the active cnt_en and, in mode 0, conv_en, then -> DRAIN.
- DRAIN:
  - Wait for result_done, then -> CLEAR.
  - A result_done seen during RUN, including in the same cycle as scan_done, is latched in a pending flag. DRAIN then exits after 1 cycle.
- CLEAR (1 cycle): clear=1, wr_en=0, conv_en=0, then -> NEXT.
- NEXT:
  - If layer_idx==NUM_LAYERS-1 -> IDLE with done=1, busy=0, sel=0.
  - Otherwise increment layer_idx and -> LOAD.
- Latencies:
  - start to first cnt_en: 2 cycles.
  - result_done to clear: 1 cycle (DRAIN is exited on the next edge).
- done holds until the next accepted start. start while busy=1 is ignored.
- abort in LOAD, RUN or DRAIN:
  - Next cycle is CLEAR (clear=1; all enables 0), then IDLE with busy=0, done=0.
  - abort in CLEAR or NEXT also completes in IDLE with done=0.
- rst mid-sequence: immediate return to reset values, including the table.
- Simultaneous abort and scan_done: abort wins.
- Simultaneous start and abort in IDLE: start is accepted.

Optional Feature:
- Macro CONV_SCHED_WDOG_EN.
- When defined:
  - A WDOG_W-bit counter clears on entry to RUN and DRAIN and increments while in either state.
  - On all-ones it forces an abort path (CLEAR then IDLE) and sets err=1, held until the next accepted start.
- When undefined: no counter; err is tied 0.

Test Plan:
- Program 3 entries: (3,3,30,27,sel1,m0), (3,3,440,340,sel2,m0), (28,25,438,338,sel3,m1). Pulse start; model scan_done 20 cycles after each cnt_en rise and result_done 3 cycles later. Expect:
  - sel sequence 1,2,3;
  - exactly 3 single-cycle clear pulses;
  - cnt_en_l2 only in layer 2;
  - done=1 and busy=0 after the third NEXT.
- Entry 1 has ht_sm=0 -> after layer 0: done=1, layer_idx=1, no cnt_en activity for layer 1.
- scan_done and result_done in the same cycle in layer 0 -> DRAIN lasts 1 cycle; clear asserts 2 cycles after the pulse.
- abort in the 5th RUN cycle of layer 1 -> clear=1 next cycle, then busy=0 and done=0. A following start restarts at layer_idx=0.
- cfg_we to entry 0 with ht_sm=5 while busy -> entry keeps 3; a second start after done drives ht_sm=3.
- With CONV_SCHED_WDOG_EN and WDOG_W=4: withhold scan_done -> after 15 RUN cycles, clear pulses, err=1, done=0.
